// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D cache memory-port arbiter: FSM state encoding
// and the cache-line container.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arbiter_state_t;

  typedef logic [255:0] cache_line_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port line arbiter between instruction and data caches: data side wins
// by default, instruction side is forced after STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output arbiter_state_t        dbg_state,
  output logic [CNT_W-1:0]      dbg_starve_cnt
);

  // Handshake: each cache holds its request level-high until it sees its own
  // resp; resp is a one-cycle pulse, combinational from pmem_resp, issued only
  // while that cache owns the port. Memory strobes stay high until pmem_resp.

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arbiter_state_t          state, next_state;
  logic [CNT_W-1:0]        starve_cnt;
  logic [ADDR_WIDTH-1:0]   hold_addr;
  logic [LINE_WIDTH-1:0]   hold_wdata;
  logic                    hold_write;
  logic                    grant_i, grant_d;
  logic                    d_req, i_forced;

  assign d_req    = d_read | d_write;
  assign i_forced = i_read && (starve_cnt == STARVE_MAX);

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !i_forced) begin
          grant_d    = 1'b1;
          next_state = SERVE_D;
        end else if (i_read) begin
          grant_i    = 1'b1;
          next_state = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: if (pmem_resp) next_state = RELEASE;
      RELEASE:          next_state = IDLE;
      default:          next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_write <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_d) begin
        hold_addr  <= d_address;
        hold_wdata <= d_wdata;
        hold_write <= d_write;  // write wins if the cache illegally raises both
        if (!i_read)                       starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
      end else if (grant_i) begin
        hold_addr  <= i_address;
        hold_wdata <= '0;
        hold_write <= 1'b0;
        starve_cnt <= '0;
      end
    end
  end

  // Strobes come only from the hold registers, never from live cache inputs.
  assign pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !hold_write);
  assign pmem_write   = (state == SERVE_D) && hold_write;
  assign pmem_address = hold_addr;
  assign pmem_wdata   = hold_wdata;

  assign i_resp  = (state == SERVE_I) && pmem_resp;
  assign d_resp  = (state == SERVE_D) && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level ownership model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int SL = 4;
  localparam int CW = $clog2(SL + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  cache_line_t   pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  arbiter_state_t dbg_state;
  logic [CW-1:0] dbg_starve_cnt;

  mem_port_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: who owns the port, whether we are in the
  // post-transaction gap, and how many data grants the I side has waited for.
  int            m_owner   = 0;      // 0 none, 1 instruction, 2 data
  bit            m_release = 1'b0;
  int            m_cnt     = 0;
  logic [AW-1:0] m_addr    = '0;
  logic [LW-1:0] m_wdata   = '0;
  bit            m_write   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_release = 1'b0; m_cnt = 0;
      m_addr = '0; m_wdata = '0; m_write = 1'b0;
    end else if (m_release) begin
      m_release = 1'b0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner = 0;
        m_release = 1'b1;
      end
    end else if ((d_read || d_write) && !(i_read && m_cnt == SL)) begin
      m_owner = 2; m_addr = d_address; m_wdata = d_wdata; m_write = d_write;
      m_cnt = i_read ? ((m_cnt < SL) ? m_cnt + 1 : SL) : 0;
    end else if (i_read) begin
      m_owner = 1; m_addr = i_address; m_write = 1'b0; m_cnt = 0;
    end
  end

  bit             e_read, e_write;
  arbiter_state_t e_state;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_read  = (m_owner == 1) || (m_owner == 2 && !m_write);
      e_write = (m_owner == 2) && m_write;
      e_state = m_release ? RELEASE : (m_owner == 1) ? SERVE_I : (m_owner == 2) ? SERVE_D : IDLE;
      check("pmem_read",  256'(pmem_read),  256'(e_read));
      check("pmem_write", 256'(pmem_write), 256'(e_write));
      check("i_resp", 256'(i_resp), 256'(m_owner == 1 && pmem_resp));
      check("d_resp", 256'(d_resp), 256'(m_owner == 2 && pmem_resp));
      check("i_rdata", i_rdata, pmem_rdata);
      check("d_rdata", d_rdata, pmem_rdata);
      check("state", 256'(dbg_state), 256'(e_state));
      check("starve_cnt", 256'(dbg_starve_cnt), 256'(m_cnt));
      if (e_read || e_write) check("pmem_address", 256'(pmem_address), 256'(m_addr));
      if (e_write) check("pmem_wdata", pmem_wdata, m_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for a strobe, answer after lat extra cycles, report owner.
  task automatic mem_respond(input int lat, output int owner);
    int n;
    n = 0;
    owner = 0;
    while (!(pmem_read || pmem_write) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL strobe_timeout @%0t: got no strobe required strobe within 50 cycles", $time);
    end else begin
      repeat (lat) tick();
      pmem_resp = 1'b1;
      #2;
      owner = i_resp ? 1 : (d_resp ? 2 : 0);
      tick();
      pmem_resp = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run required finish before 200000");
    $fatal(1, "watchdog");
  end

  int own;

  initial begin
    pmem_rdata = {8{$urandom()}};
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_pmem_read", 256'(pmem_read), 256'(0));
    check("rst_pmem_write", 256'(pmem_write), 256'(0));
    check("rst_pmem_address", 256'(pmem_address), 256'(0));
    check("rst_pmem_wdata", pmem_wdata, 256'(0));
    check("rst_state", 256'(dbg_state), 256'(IDLE));

    // Single instruction read, memory answers in cycle 4.
    i_read = 1'b1; i_address = 32'h0000_0040;
    tick();                                              // cycle 1
    check("t1_strobe_c1", 256'(pmem_read), 256'(1));
    tick(); tick(); tick();                              // cycle 4
    pmem_resp = 1'b1;
    #2;
    check("t1_i_resp_c4", 256'(i_resp), 256'(1));
    check("t1_d_resp_c4", 256'(d_resp), 256'(0));
    check("t1_addr", 256'(pmem_address), 256'(32'h40));
    tick();                                              // cycle 5 release
    pmem_resp = 1'b0; i_read = 1'b0;
    check("t1_release_strobe", 256'(pmem_read), 256'(0));
    check("t1_release_resp", 256'(i_resp), 256'(0));
    tick();

    // Simultaneous i_read and d_write: write-back goes first.
    pmem_rdata = {8{$urandom()}};
    i_read = 1'b1; i_address = 32'h0000_0080;
    d_write = 1'b1; d_address = 32'h0000_0100; d_wdata = {32{8'hA5}};
    tick();
    check("t2_write_first", 256'(pmem_write), 256'(1));
    check("t2_addr", 256'(pmem_address), 256'(32'h100));
    check("t2_wdata", pmem_wdata, {32{8'hA5}});
    mem_respond(1, own);
    check("t2_owner1", 256'(own), 256'(2));
    d_write = 1'b0;
    mem_respond(1, own);
    check("t2_owner2", 256'(own), 256'(1));
    i_read = 1'b0;
    tick();

    // Starvation: i_read held against continuous d_read.
    i_read = 1'b1; i_address = 32'h0000_00C0;
    d_read = 1'b1; d_address = 32'h0000_0140;
    for (int k = 0; k < 5; k++) begin
      mem_respond(0, own);
      check("t3_owner_seq", 256'(own), 256'((k < 4) ? 2 : 1));
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
    check("t3_cnt_cleared", 256'(dbg_starve_cnt), 256'(0));

    // Address changes mid-transaction must not reach the port.
    d_read = 1'b1; d_address = 32'h0000_0200;
    tick();
    d_address = 32'h0000_0300;
    tick();
    check("t4_addr_latched", 256'(pmem_address), 256'(32'h200));
    mem_respond(0, own);
    check("t4_owner", 256'(own), 256'(2));
    d_read = 1'b0;
    tick();

    // Reset in cycle 2 of a write-back abandons it.
    d_write = 1'b1; d_address = 32'h0000_0400; d_wdata = {8{$urandom()}};
    tick(); tick();
    rst = 1'b1;
    #1;
    check("t5_rst_write", 256'(pmem_write), 256'(0));
    check("t5_rst_state", 256'(dbg_state), 256'(IDLE));
    d_write = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    pmem_resp = 1'b1;
    #2;
    check("t5_late_d_resp", 256'(d_resp), 256'(0));
    check("t5_late_i_resp", 256'(i_resp), 256'(0));
    tick();
    pmem_resp = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_0500;
    mem_respond(2, own);
    check("t5_fresh_owner", 256'(own), 256'(1));
    i_read = 1'b0;
    tick(); tick();

    // Spurious pmem_resp while idle.
    pmem_resp = 1'b1;
    #2;
    check("t6_i_resp", 256'(i_resp), 256'(0));
    check("t6_d_resp", 256'(d_resp), 256'(0));
    tick();
    pmem_resp = 1'b0;
    check("t6_state", 256'(dbg_state), 256'(IDLE));
    tick(); tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single physical-memory line port between the instruction cache and the data cache of the pipelined RV32I core. Each cache issues whole-line read or write-back requests; the arbiter grants one at a time, latches that request onto the memory port, and returns the response only to its owner. Data-side requests win by default; a starvation counter forces an instruction-side grant after a bounded run of data grants.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- ADDR_WIDTH, 32, byte address width (line-aligned addresses)
- STARVE_LIMIT, 4, consecutive data grants made while an instruction request is pending before the instruction side is forced
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- i_read  in  1  instruction-cache line read request; held until i_resp
- i_address  in  ADDR_WIDTH  instruction line address
- i_rdata  out  LINE_WIDTH  read line to instruction cache
- i_resp  out  1  one-cycle completion pulse to instruction cache
- d_read  in  1  data-cache line read request; held until d_resp
- d_write  in  1  data-cache write-back request; held until d_resp
- d_address  in  ADDR_WIDTH  data line address
- d_wdata  in  LINE_WIDTH  write-back line
- d_rdata  out  LINE_WIDTH  read line to data cache
- d_resp  out  1  one-cycle completion pulse to data cache
- pmem_read  out  1  memory read strobe, held for whole transaction
- pmem_write  out  1  memory write strobe, held for whole transaction
- pmem_address  out  ADDR_WIDTH  latched transaction address
- pmem_wdata  out  LINE_WIDTH  latched write line
- pmem_rdata  in  LINE_WIDTH  memory read line, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: if any request pending, choose owner and latch address/wdata/direction into hold registers at the edge. Choice: d request wins, unless i_read pending and starve_cnt == STARVE_LIMIT, then i wins.
- d_read and d_write both high is illegal; d_write takes precedence.
- SERVE_x: pmem_read/pmem_write driven from hold registers, never from live cache inputs. On pmem_resp: owner's resp = 1 that cycle, other resp = 0; next state RELEASE.
- RELEASE: one idle cycle, no strobes, no requests sampled; lets owner drop its request. Then IDLE.
- i_rdata = d_rdata = pmem_rdata (unqualified); only resp is gated.
- starve_cnt (width clog2(STARVE_LIMIT+1)): at a d grant with i_read pending, increment (saturate at STARVE_LIMIT); at any i grant, clear; at a d grant with no i_read pending, clear.
- pmem_resp in IDLE or RELEASE ignored; no resp generated.

## Timing
- Reset (async, immediate): state IDLE, starve_cnt 0, hold registers 0; all outputs 0 except rdata pass-through. In-flight memory transaction abandoned; no resp ever issued for it.
- Request seen high in IDLE at cycle 0 -> strobe high cycle 1 -> stays high through the pmem_resp cycle k -> resp to owner in cycle k (combinational from pmem_resp) -> RELEASE cycle k+1 -> IDLE cycle k+2; earliest next strobe cycle k+3.
- Requests arriving during SERVE_x or RELEASE wait; no preemption.
- Minimum transaction: pmem_resp in cycle 1 -> resp cycle 1; back-to-back grants every 3 cycles.

## Structure
- Shared types package gets arbiter_state_t (IDLE, SERVE_I, SERVE_D, RELEASE) and a cache-line typedef logic [255:0].
- Single module; starvation counter inline, no sub-module.

## Test plan
- Reset then i_read=1, i_address=0x0000_0040, pmem_resp in cycle 4 -> pmem_read 1 cycles 1-4, pmem_address 0x40, i_resp pulse cycle 4 only, d_resp 0.
- i_read and d_write (0x100, wdata 0xA5..A5) both high in IDLE -> pmem_write with 0x100/A5 first; i_read served after RELEASE; i_resp only on second transaction.
- i_read held, d_read re-asserted after each d_resp, STARVE_LIMIT=4 -> exactly 4 d grants then 1 i grant; starve_cnt back to 0.
- Change d_address mid SERVE_D -> pmem_address stays latched value.
- Assert rst in cycle 2 of SERVE_D -> all strobes/resps 0 immediately; later pmem_resp ignored; fresh i_read served normally.
- Spurious pmem_resp in IDLE -> no i_resp/d_resp, state stays IDLE.
